// File: rtl/count_display_driver_pkg.sv
// display_pkg: converter state type, digit count and 7-segment codes for a common-anode display.
// Segment codes are {g,f,e,d,c,b,a}, active-low. Optional feature macro: LEADING_ZERO_BLANK_EN (used by the top).
package display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  localparam int DIGITS = 4;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/count_display_driver_if.sv
// count_display_driver_if: value in, BCD/status and display pins out.
// Ports: value[N-1:0], bcd[15:0], busy, an[3:0], seg[6:0], dp. master = producer/observer side, slave = driver side.
interface count_display_driver_if #(parameter int N = 8);
  logic [N-1:0] value;
  logic [15:0]  bcd;
  logic         busy;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp;
  modport master (output value, input bcd, busy, an, seg, dp);
  modport slave  (input value, output bcd, busy, an, seg, dp);
endinterface

// File: rtl/count_display_driver_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter, one conversion every N+2 cycles.
// Ports: clock, reset (async active-low), value[N-1:0] in, bcd[15:0] last completed result, busy (SHIFT or DONE).
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] value,
  output logic [15:0]  bcd,
  output logic         busy
);
  localparam int CW = $clog2(N + 1);
  conv_state_t   r_state;
  logic [N-1:0]  r_sh;
  logic [15:0]   r_scr;
  logic [15:0]   r_bcd;
  logic [CW-1:0] r_cnt;
  logic [15:0]   w_adj;
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < 4; i++)
      w_adj[4*i +: 4] = r_scr[4*i +: 4] >= 4'd5 ? r_scr[4*i +: 4] + 4'd3 : r_scr[4*i +: 4];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sh    <= value;
          r_scr   <= '0;
          r_cnt   <= CW'(N);
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_scr   <= {w_adj[14:0], r_sh[N-1]};
          r_sh    <= r_sh << 1;
          r_cnt   <= r_cnt - CW'(1);
          r_state <= r_cnt == CW'(1) ? DONE : SHIFT;
        end
        DONE: begin
          r_bcd   <= r_scr;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bcd  = r_bcd;
  assign busy = r_state != IDLE;
endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: binary count -> BCD -> 4-digit multiplexed common-anode 7-segment display.
// Ports: clock, reset (async active-low), bus (slave: value in; bcd, busy, an, seg, dp out).
// Macro LEADING_ZERO_BLANK_EN: blank digits above the most significant non-zero digit.
module count_display_driver
  import display_pkg::*;
#(
  parameter int N           = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  count_display_driver_if.slave bus
);
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [RW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic [15:0]   w_bcd;
  logic [3:0]    w_nib;
  logic          w_lit;
  logic          w_wrap;
  bin2bcd_seq #(.N(N)) u_conv (
    .clock (clock),
    .reset (reset),
    .value (bus.value),
    .bcd   (w_bcd),
    .busy  (bus.busy)
  );
  assign w_nib  = w_bcd[{r_sel, 2'b00} +: 4];
  assign w_wrap = r_cnt == RW'(REFRESH_DIV - 1);
`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] w_msd;
  // digit 0 is always lit so a zero value still shows one "0"
  assign w_msd = |w_bcd[15:12] ? 2'd3 : |w_bcd[11:8] ? 2'd2 : |w_bcd[7:4] ? 2'd1 : 2'd0;
  assign w_lit = r_sel <= w_msd;
`else
  assign w_lit = 1'b1;
`endif
  // an and seg are registered from the same digit_sel so they always switch together
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sel <= '0;
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + RW'(1);
      r_sel <= w_wrap ? r_sel + 2'd1 : r_sel;
      r_an  <= w_lit ? ~(4'b0001 << r_sel) : 4'b1111;
      r_seg <= w_lit ? seg_decode(w_nib) : SEG_BLANK;
    end
  end
  assign bus.bcd = w_bcd;
  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = 1'b1;
endmodule

// File: tb/tb_count_display_driver.sv
// tb_count_display_driver: randomized self-checking bench against a decimal/scan-timing reference model.
module tb_count_display_driver;
  localparam int NA = 8;
  localparam int NB = 13;
  localparam int RD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  count_display_driver_if #(.N(NA)) ifa();
  count_display_driver_if #(.N(NB)) ifb();
  count_display_driver #(.N(NA), .REFRESH_DIV(RD)) dut_a (.clock(clk), .reset(rst_n), .bus(ifa.slave));
  count_display_driver #(.N(NB), .REFRESH_DIV(RD)) dut_b (.clock(clk), .reset(rst_n), .bus(ifb.slave));
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};
  int checks = 0;
  int errors = 0;
  int k, cap, val, m_sel, m_dig;
  logic       exp_busy;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic lit(input int v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    return d == 0 || v >= (d == 1 ? 10 : d == 2 ? 100 : 1000);
`else
    return 1'b1;
`endif
  endfunction
  // reference model for instance A: k counts clock edges since reset release
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      k = 0; cap = 0; val = 0;
      exp_busy = 1'b0; exp_an = 4'b1111; exp_seg = 7'b1111111;
    end else begin
      k++;
      m_sel = ((k - 1) / RD) % 4;
      m_dig = (val / pow10[m_sel]) % 10;
      exp_an  = lit(val, m_sel) ? ~(4'b0001 << m_sel) : 4'b1111;
      exp_seg = lit(val, m_sel) ? seg_tab[m_dig] : 7'b1111111;
      if (k % (NA + 2) == 1) cap = int'(ifa.value);
      if (k % (NA + 2) == 0) val = cap;
      exp_busy = k % (NA + 2) != 0;
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    ifa.value = 8'd77;
    ifb.value = '0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (ifa.bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h want 0000", ifa.bcd); end
    if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
    if (ifa.an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", ifa.an); end
    if (ifa.seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b want 1111111", ifa.seg); end
    if (ifa.dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", ifa.dp); end
    if (ifb.bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd_b got %h want 0000", ifb.bcd); end
    rst_n = 1'b1;
  endtask
  task automatic test_hold_255();
    int nbusy = 0;
    ifa.value = 8'd255;
    do_reset();
    for (int c = 1; c <= 2 * (NA + 2); c++) begin
      @(negedge clk);
      checks += 4;
      if (ifa.bcd !== to_bcd(val)) begin errors++; $display("FAIL hold_bcd k=%0d got %h want %h", k, ifa.bcd, to_bcd(val)); end
      if (ifa.busy !== exp_busy) begin errors++; $display("FAIL hold_busy k=%0d got %b want %b", k, ifa.busy, exp_busy); end
      if (ifa.an !== exp_an) begin errors++; $display("FAIL hold_an k=%0d got %b want %b", k, ifa.an, exp_an); end
      if (ifa.seg !== exp_seg) begin errors++; $display("FAIL hold_seg k=%0d got %b want %b", k, ifa.seg, exp_seg); end
      if (c > NA + 2 && ifa.busy === 1'b1) nbusy++;
    end
    checks += 3;
    if (ifa.bcd !== 16'h0255) begin errors++; $display("FAIL hold_final got %h want 0255", ifa.bcd); end
    if (nbusy != NA + 1) begin errors++; $display("FAIL hold_duty got %0d want %0d", nbusy, NA + 1); end
    if (ifa.dp !== 1'b1) begin errors++; $display("FAIL hold_dp got %b want 1", ifa.dp); end
  endtask
  task automatic test_mid_reset();
    ifa.value = 8'd200;
    do_reset();
    repeat (NA + 6) @(negedge clk);
    checks += 2;
    if (ifa.bcd !== 16'h0200) begin errors++; $display("FAIL midrst_pre_bcd got %h want 0200", ifa.bcd); end
    if (ifa.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", ifa.busy); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (ifa.bcd !== 16'h0000) begin errors++; $display("FAIL midrst_bcd got %h want 0000", ifa.bcd); end
    if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", ifa.busy); end
    if (ifa.an !== 4'b1111) begin errors++; $display("FAIL midrst_an got %b want 1111", ifa.an); end
    if (ifa.seg !== 7'b1111111) begin errors++; $display("FAIL midrst_seg got %b want 1111111", ifa.seg); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_change();
    ifa.value = 8'd99;
    do_reset();
    repeat (3) @(negedge clk);
    ifa.value = 8'd100;
    repeat (3 * (NA + 2)) begin
      @(negedge clk);
      checks += 3;
      if (ifa.bcd !== to_bcd(val)) begin errors++; $display("FAIL change_bcd k=%0d got %h want %h", k, ifa.bcd, to_bcd(val)); end
      if (!(ifa.bcd inside {16'h0000, 16'h0099, 16'h0100})) begin errors++; $display("FAIL change_mix got %h want 0000/0099/0100", ifa.bcd); end
      if (ifa.busy !== exp_busy) begin errors++; $display("FAIL change_busy k=%0d got %b want %b", k, ifa.busy, exp_busy); end
    end
    checks++;
    if (ifa.bcd !== 16'h0100) begin errors++; $display("FAIL change_final got %h want 0100", ifa.bcd); end
  endtask
  task automatic test_random();
    do_reset();
    repeat (12) begin
      ifa.value = 8'($urandom);
      repeat ($urandom_range(1, 25)) begin
        @(negedge clk);
        checks += 4;
        if (ifa.bcd !== to_bcd(val)) begin errors++; $display("FAIL rand_bcd k=%0d got %h want %h", k, ifa.bcd, to_bcd(val)); end
        if (ifa.busy !== exp_busy) begin errors++; $display("FAIL rand_busy k=%0d got %b want %b", k, ifa.busy, exp_busy); end
        if (ifa.an !== exp_an) begin errors++; $display("FAIL rand_an k=%0d got %b want %b", k, ifa.an, exp_an); end
        if (ifa.seg !== exp_seg) begin errors++; $display("FAIL rand_seg k=%0d got %b want %b", k, ifa.seg, exp_seg); end
      end
    end
  endtask
  task automatic test_refresh();
    int vals [2] = '{8, 0};
    for (int j = 0; j < 2; j++) begin
      ifa.value = 8'(vals[j]);
      do_reset();
      repeat (40) begin
        @(negedge clk);
        checks += 2;
        if (ifa.an !== exp_an) begin errors++; $display("FAIL scan_an v=%0d k=%0d got %b want %b", vals[j], k, ifa.an, exp_an); end
        if (ifa.seg !== exp_seg) begin errors++; $display("FAIL scan_seg v=%0d k=%0d got %b want %b", vals[j], k, ifa.seg, exp_seg); end
        if (k > NA + 2 && ifa.an === 4'b1110) begin
          checks++;
          if (ifa.seg !== (vals[j] == 8 ? 7'b0000000 : 7'b1000000)) begin errors++; $display("FAIL scan_digit0 v=%0d got %b", vals[j], ifa.seg); end
        end
      end
    end
  endtask
  task automatic test_wide();
    logic seen = 1'b0;
    ifb.value = 13'd8191;
    do_reset();
    repeat (2 * (NB + 2)) @(negedge clk);
    checks++;
    if (ifb.bcd !== 16'h8191) begin errors++; $display("FAIL wide_8191 got %h want 8191", ifb.bcd); end
    ifb.value = 13'd5;
    repeat (2 * (NB + 2)) @(negedge clk);
    checks++;
    if (ifb.bcd !== 16'h0005) begin errors++; $display("FAIL wide_5 got %h want 0005", ifb.bcd); end
    repeat (4 * RD) begin
      @(negedge clk);
      if (ifb.an === 4'b1110) begin
        seen = 1'b1;
        checks++;
        if (ifb.seg !== 7'b0010010) begin errors++; $display("FAIL wide_seg got %b want 0010010", ifb.seg); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wide_scan got no digit0 want an=1110 within %0d cycles", 4 * RD); end
  endtask
  initial begin
    test_reset();
    test_hold_255();
    test_mid_reset();
    test_change();
    test_random();
    test_refresh();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
